// File: rtl/hog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hog_pkg
// Brief    : Shared HOG constants and output-switch state encoding.
// Revision : 1.0
// ============================================================================
package hog_pkg;

    localparam int HOG_LEVELS     = 7;
    localparam int HOG_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/hog_out_switch_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin pick from a request vector, starting after last grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import hog_pkg::*;
#(
    parameter  int LEVELS    = HOG_LEVELS,
    localparam int IDX_WIDTH = $clog2(LEVELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEVELS-1:0]    req_i,
    input  logic                 update_i,
    output logic                 pick_valid_o,
    output logic [IDX_WIDTH-1:0] pick_idx_o,
    output logic [LEVELS-1:0]    pick_onehot_o,
    output logic [IDX_WIDTH-1:0] last_grant_o
);

    localparam logic [IDX_WIDTH:0] LEVELS_W = (IDX_WIDTH+1)'(LEVELS);

    logic [IDX_WIDTH-1:0] last_grant_q;
    logic [IDX_WIDTH:0]   cand_sum;
    logic [IDX_WIDTH-1:0] cand_idx;

    // Walk offsets 1..LEVELS from the last grant so the last winner is tried last.
    always_comb begin
        pick_valid_o  = 1'b0;
        pick_idx_o    = '0;
        pick_onehot_o = '0;
        cand_sum      = '0;
        cand_idx      = '0;
        for (int k = 1; k <= LEVELS; k++) begin
            cand_sum = {1'b0, last_grant_q} + (IDX_WIDTH+1)'(k);
            if (cand_sum >= LEVELS_W) begin
                cand_sum = cand_sum - LEVELS_W;
            end
            cand_idx = cand_sum[IDX_WIDTH-1:0];
            if (!pick_valid_o && req_i[cand_idx]) begin
                pick_valid_o = 1'b1;
                pick_idx_o   = cand_idx;
            end
        end
        pick_onehot_o[pick_idx_o] = pick_valid_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_WIDTH'(LEVELS-1);
        end else if (update_i) begin
            last_grant_q <= pick_idx_o;
        end
    end

    assign last_grant_o = last_grant_q;

endmodule
`default_nettype wire

// File: rtl/hog_out_switch.sv
`default_nettype none
// ============================================================================
// Module   : hog_out_switch
// Brief    : Round-robin burst switch merging per-level HOG streams into one.
// Revision : 1.0
// ============================================================================
module hog_out_switch
    import hog_pkg::*;
#(
    parameter  int LEVELS     = HOG_LEVELS,
    parameter  int DATA_WIDTH = HOG_DATA_WIDTH,
    parameter  int BURST_LEN  = 16,
    localparam int IDX_WIDTH  = $clog2(LEVELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LEVELS-1:0]            in_valid,
    output logic [LEVELS-1:0]            in_ready,
    input  logic [LEVELS*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [IDX_WIDTH-1:0]         out_level,
    output logic                         out_last,
    output logic [LEVELS-1:0]            grant,
    output logic                         busy
);

    localparam int                   CNT_WIDTH = $clog2(BURST_LEN+1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(BURST_LEN-1);

    sw_state_e              state_q, state_d;
    logic [LEVELS-1:0]      grant_q, grant_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [IDX_WIDTH-1:0]   out_level_q, out_level_d;

    logic                   arb_update;
    logic                   pick_valid;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic [LEVELS-1:0]      pick_onehot;
    logic [IDX_WIDTH-1:0]   gidx;

    logic                   in_grant_state;
    logic                   can_load;
    logic                   valid_g;
    logic [DATA_WIDTH-1:0]  data_g;
    logic                   xfer;

    rr_arbiter #(
        .LEVELS (LEVELS)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .req_i         (in_valid),
        .update_i      (arb_update),
        .pick_valid_o  (pick_valid),
        .pick_idx_o    (pick_idx),
        .pick_onehot_o (pick_onehot),
        .last_grant_o  (gidx)
    );

    assign in_grant_state = (state_q == ST_GRANT);
    assign can_load       = !out_valid_q || out_ready;
    assign xfer           = in_grant_state && can_load && valid_g;

    // The arbiter's last-grant register doubles as the granted level index.
    always_comb begin
        valid_g = 1'b0;
        data_g  = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (gidx == IDX_WIDTH'(i)) begin
                valid_g = in_valid[i];
                data_g  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_level_d = out_level_q;
        arb_update  = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    arb_update = 1'b1;
                    grant_d    = pick_onehot;
                    cnt_d      = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    out_valid_d = 1'b1;
                    out_data_d  = data_g;
                    out_level_d = gidx;
                    out_last_d  = (cnt_q == LAST_CNT);
                    cnt_d       = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (can_load && !valid_g) begin
                    // Requester went quiet while the output could accept: give up early.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_level_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_level_q <= out_level_d;
        end
    end

    assign in_ready  = (in_grant_state && can_load) ? grant_q : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_level = out_level_q;
    assign out_last  = out_last_q;
    assign grant     = grant_q;
    assign busy      = in_grant_state;

endmodule
`default_nettype wire

// File: tb/tb_hog_out_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_hog_out_switch
// Brief    : Directed self-checking bench with a cycle model and beat log.
// Revision : 1.0
// ============================================================================
module tb_hog_out_switch;

    localparam int LEVELS = 7;
    localparam int DW     = 32;
    localparam int BL     = 16;
    localparam int IW     = $clog2(LEVELS);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [LEVELS-1:0]    in_valid = '0;
    logic [LEVELS-1:0]    in_ready;
    logic [LEVELS*DW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [DW-1:0]        out_data;
    logic [IW-1:0]        out_level;
    logic                 out_last;
    logic [LEVELS-1:0]    grant;
    logic                 busy;

    hog_out_switch #(
        .LEVELS     (LEVELS),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_level (out_level),
        .out_last  (out_last),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus state: each level emits (level<<8)+seq until seq reaches lim.
    int                seq [LEVELS];
    int                lim [LEVELS];
    logic [LEVELS-1:0] en = '0;
    logic [LEVELS-1:0] hs = '0;
    bit                bp_mode = 1'b0;
    logic [3:0]        bp_pat = 4'b1001;
    int                cyc = 0;
    int                ncyc = 0;

    typedef struct {
        int   lvl;
        int   data;
        bit   last;
        int   cyc;
    } beat_t;
    beat_t log_q[$];

    // Reference model state
    bit                m_busy  = 1'b0;
    int                m_g     = 0;
    int                m_last  = LEVELS-1;
    int                m_cnt   = 0;
    bit                m_ov    = 1'b0;
    bit                m_olast = 1'b0;
    logic [DW-1:0]     m_od    = '0;
    logic [IW-1:0]     m_ol    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < LEVELS; i++) begin
            in_valid[i]          = en[i] && (seq[i] < lim[i]);
            in_data[i*DW +: DW]  = DW'((i << 8) + seq[i]);
        end
        out_ready = bp_mode ? bp_pat[cyc[1:0]] : 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < LEVELS; i++) begin
            if (hs[i]) seq[i]++;
        end
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = '0;
        bp_mode = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            seq[i] = 0;
            lim[i] = 1000;
        end
        drive();
        tick();
        tick();
        rst = 1'b0;
        drive();
        log_q.delete();
    endtask

    // Compare against the model, log accepted beats, then step the model.
    initial begin
        logic [LEVELS-1:0] exp_ir;
        logic [LEVELS-1:0] exp_gr;
        bit                can;
        bit                popped;
        int                j;
        forever begin
            @(negedge clk);
            ncyc++;
            can    = !m_ov || out_ready;
            exp_gr = m_busy ? LEVELS'(1 << m_g) : '0;
            exp_ir = (m_busy && can) ? exp_gr : '0;
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
            chk("out_data",  64'(out_data),      64'(m_od));
            chk("out_level", 64'(out_level),     64'(m_ol));
            chk("out_last",  {63'd0, out_last},  {63'd0, m_olast});
            chk("grant",     64'(grant),         64'(exp_gr));
            chk("busy",      {63'd0, busy},      {63'd0, m_busy});
            chk("in_ready",  64'(in_ready),      64'(exp_ir));

            if (!rst && out_valid && out_ready) begin
                log_q.push_back('{lvl: int'(out_level), data: int'(out_data),
                                  last: out_last, cyc: ncyc});
            end
            hs = rst ? '0 : (in_valid & exp_ir);

            if (rst) begin
                m_busy = 1'b0; m_ov = 1'b0; m_od = '0; m_ol = '0;
                m_olast = 1'b0; m_cnt = 0; m_last = LEVELS-1;
            end else begin
                popped = m_ov && out_ready;
                if (m_busy) begin
                    if (can && in_valid[m_g]) begin
                        m_ov    = 1'b1;
                        m_od    = in_data[m_g*DW +: DW];
                        m_ol    = IW'(m_g);
                        m_olast = (m_cnt == BL-1);
                        m_cnt++;
                        if (m_cnt == BL) m_busy = 1'b0;
                    end else begin
                        if (popped) m_ov = 1'b0;
                        if (can && !in_valid[m_g]) m_busy = 1'b0;
                    end
                end else begin
                    if (popped) m_ov = 1'b0;
                    if (in_valid != '0) begin
                        for (int k = LEVELS; k >= 1; k--) begin
                            j = (m_last + k) % LEVELS;
                            if (in_valid[j]) m_g = j;
                        end
                        m_last = m_g;
                        m_cnt  = 0;
                        m_busy = 1'b1;
                    end
                end
            end
        end
    end

    int order [6] = '{0, 2, 6, 0, 2, 6};

    initial begin
        bit reached;
        for (int i = 0; i < LEVELS; i++) begin
            seq[i] = 0;
            lim[i] = 1000;
        end
        drive();

        // Reset, then idle
        tick();
        tick();
        rst = 1'b0;
        drive();
        repeat (10) tick();
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
        chk("idle_grant",     64'(grant),         64'd0);
        chk("idle_busy",      {63'd0, busy},      64'd0);
        chk("idle_in_ready",  64'(in_ready),      64'd0);

        // Single requester, burst boundary and re-arbitration gap
        do_reset();
        en[3] = 1'b1; lim[3] = 20;
        drive();
        repeat (30) tick();
        chk("t2_count",     64'(log_q.size()), 64'd20);
        chk("t2_first",     64'(log_q[0].data),  64'h300);
        chk("t2_pre_last",  64'(log_q[14].last), 64'd0);
        chk("t2_burst_end", 64'(log_q[15].data), 64'h30F);
        chk("t2_last_flag", 64'(log_q[15].last), 64'd1);
        chk("t2_next",      64'(log_q[16].data), 64'h310);
        chk("t2_next_lvl",  64'(log_q[16].lvl),  64'd3);
        chk("t2_gap",       64'(log_q[16].cyc - log_q[15].cyc), 64'd2);
        chk("t2_inburst",   64'(log_q[1].cyc - log_q[0].cyc),   64'd1);

        // Round-robin rotation over levels 0, 2, 6
        do_reset();
        en[0] = 1'b1; en[2] = 1'b1; en[6] = 1'b1;
        drive();
        repeat (110) tick();
        en = '0;
        drive();
        repeat (20) tick();
        chk("t3_count_ge96", {63'd0, log_q.size() >= 96}, 64'd1);
        for (int k = 0; k < 6; k++) begin
            chk("t3_order",    64'(log_q[k*16].lvl),     64'(order[k]));
            chk("t3_end_lvl",  64'(log_q[k*16+15].lvl),  64'(order[k]));
            chk("t3_end_last", 64'(log_q[k*16+15].last), 64'd1);
        end

        // Backpressure on level 1
        do_reset();
        en[1] = 1'b1; lim[1] = 12; bp_mode = 1'b1;
        drive();
        repeat (40) tick();
        chk("t4_count", 64'(log_q.size()), 64'd12);
        for (int k = 0; k < 12; k++) begin
            chk("t4_data", 64'(log_q[k].data), 64'(32'h100 + k));
        end

        // Early release of level 5 after 4 beats
        do_reset();
        en[5] = 1'b1; lim[5] = 4;
        drive();
        repeat (3) tick();
        en[0] = 1'b1;
        drive();
        repeat (20) tick();
        for (int k = 0; k < 4; k++) begin
            chk("t5_lvl5_data", 64'(log_q[k].data), 64'(32'h500 + k));
            chk("t5_lvl5_last", 64'(log_q[k].last), 64'd0);
        end
        chk("t5_next_lvl",  64'(log_q[4].lvl),  64'd0);
        chk("t5_next_data", 64'(log_q[4].data), 64'h000);

        // Reset in the middle of a level 4 burst
        do_reset();
        en[4] = 1'b1;
        drive();
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            tick();
            if (seq[4] == 7) reached = 1'b1;
        end
        chk("t6_reach_beat7", {63'd0, reached}, 64'd1);
        rst = 1'b1;
        drive();
        tick();
        chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_grant", 64'(grant),         64'd0);
        chk("t6_rst_busy",  {63'd0, busy},      64'd0);
        rst = 1'b0;
        en[0] = 1'b1;
        drive();
        log_q.delete();
        repeat (10) tick();
        chk("t6_has_beats", {63'd0, log_q.size() > 0}, 64'd1);
        chk("t6_first_lvl", 64'(log_q[0].lvl), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
